// File: rtl/msg_arb_2to1_if.sv
// Four-phase message channel: req/ack handshake carrying src/dst/dat/red.
// The master drives req and the message fields; the slave answers with ack.
interface msg_arb_2to1_if #(
    parameter int ASZ = 8,
    parameter int DSZ = 16,
    parameter int RSZ = 4
);
    logic           req;
    logic           ack;
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;

    modport master (output req, src, dst, dat, red, input ack);
    modport slave  (input req, src, dst, dat, red, output ack);
endinterface

// File: rtl/msg_arb_2to1.sv
// Round-robin 2:1 message arbiter. Grant one cycle after req, o0 req one cycle after the winner's req drops.
// A stalled sink holds the message in the holding register; neither input is acked until the arbiter is back in IDLE.
module msg_arb_2to1 #(
    parameter int ASZ     = 8,
    parameter int DSZ     = 16,
    parameter int RSZ     = 4,
    parameter int CNT_SZ  = 8,
    parameter bit CHK_RED = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    msg_arb_2to1_if.slave     i0,
    msg_arb_2to1_if.slave     i1,
    msg_arb_2to1_if.master    o0,
    output logic              red_err,
    output logic              last_gnt,
    output logic [CNT_SZ-1:0] fwd_cnt0,
    output logic [CNT_SZ-1:0] fwd_cnt1
);
    localparam int MSZ = 2 * ASZ + DSZ;
    localparam int NCH = (MSZ + RSZ - 1) / RSZ;
    localparam int PSZ = NCH * RSZ;

    typedef enum logic [1:0] {IDLE, REL, SEND, DRAIN} state_t;

    state_t         state, state_nxt;
    logic           gnt;
    logic           win, win_req, req_any, red_bad;
    logic           ack0_q, ack1_q, oreq_q;
    logic           ack0_nxt, ack1_nxt, oreq_nxt;
    logic           capture, retire;
    logic [ASZ-1:0] win_src, win_dst, hold_src, hold_dst;
    logic [DSZ-1:0] win_dat, hold_dat;
    logic [RSZ-1:0] win_red, hold_red;

    // Redundancy code: XOR of the {src,dst,dat} word folded into RSZ-bit chunks.
    function automatic logic [RSZ-1:0] calc_redun(input logic [MSZ-1:0] v);
        logic [PSZ-1:0] p;
        logic [RSZ-1:0] r;
        p = PSZ'(v);
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            r = r ^ p[c*RSZ +: RSZ];
        end
        return r;
    endfunction

    assign req_any = i0.req | i1.req;
    assign win     = (i0.req & i1.req) ? ~last_gnt : i1.req;
    assign win_src = win ? i1.src : i0.src;
    assign win_dst = win ? i1.dst : i0.dst;
    assign win_dat = win ? i1.dat : i0.dat;
    assign win_red = win ? i1.red : i0.red;
    assign win_req = gnt ? i1.req : i0.req;
    assign red_bad = calc_redun({win_src, win_dst, win_dat}) != win_red;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_any)  state_nxt = REL;
            REL:     if (!win_req) state_nxt = SEND;
            SEND:    if (o0.ack)   state_nxt = DRAIN;
            DRAIN:   if (!o0.ack)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Next values of the registered handshake outputs plus datapath strobes.
    always_comb begin
        ack0_nxt = ack0_q;
        ack1_nxt = ack1_q;
        oreq_nxt = oreq_q;
        capture  = 1'b0;
        retire   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    capture  = 1'b1;
                    ack0_nxt = ~win;
                    ack1_nxt = win;
                end
            end
            REL: begin
                if (!win_req) begin
                    ack0_nxt = 1'b0;
                    ack1_nxt = 1'b0;
                    oreq_nxt = 1'b1;
                end
            end
            SEND:    if (o0.ack)  oreq_nxt = 1'b0;
            DRAIN:   if (!o0.ack) retire   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            oreq_q   <= 1'b0;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            red_err  <= 1'b0;
            hold_src <= '0;
            hold_dst <= '0;
            hold_dat <= '0;
            hold_red <= '0;
            fwd_cnt0 <= '0;
            fwd_cnt1 <= '0;
        end else begin
            ack0_q <= ack0_nxt;
            ack1_q <= ack1_nxt;
            oreq_q <= oreq_nxt;
            if (capture) begin
                gnt      <= win;
                hold_src <= win_src;
                hold_dst <= win_dst;
                hold_dat <= win_dat;
                hold_red <= win_red;
                if (CHK_RED && red_bad) begin
                    red_err <= 1'b1;
                end
            end
            if (retire) begin
                last_gnt <= gnt;
                if (gnt) begin
                    fwd_cnt1 <= fwd_cnt1 + 1'b1;
                end else begin
                    fwd_cnt0 <= fwd_cnt0 + 1'b1;
                end
            end
        end
    end

    assign i0.ack = ack0_q;
    assign i1.ack = ack1_q;
    assign o0.req = oreq_q;
    assign o0.src = hold_src;
    assign o0.dst = hold_dst;
    assign o0.dat = hold_dat;
    assign o0.red = hold_red;
endmodule

// File: tb/tb_msg_arb_2to1.sv
// Bench for msg_arb_2to1: a checked instance plus a mirror instance (no red check, 2-bit counters)
// fed the same stimulus, both compared against a transaction-level arbitration model.
module tb_msg_arb_2to1;
    localparam int ASZ = 8;
    localparam int DSZ = 16;
    localparam int RSZ = 4;

    typedef struct packed {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [15:0] dat;
        logic [3:0]  red;
    } msg_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    msg_arb_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) i0 ();
    msg_arb_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) i1 ();
    msg_arb_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) o0 ();
    msg_arb_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) b_i0 ();
    msg_arb_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) b_i1 ();
    msg_arb_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) b_o0 ();

    logic       red_err, last_gnt, b_red_err, b_last_gnt;
    logic [7:0] cnt0, cnt1;
    logic [1:0] b_cnt0, b_cnt1;

    msg_arb_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .CNT_SZ(8), .CHK_RED(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .i0(i0), .i1(i1), .o0(o0),
        .red_err(red_err), .last_gnt(last_gnt), .fwd_cnt0(cnt0), .fwd_cnt1(cnt1)
    );

    msg_arb_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .CNT_SZ(2), .CHK_RED(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .i0(b_i0), .i1(b_i1), .o0(b_o0),
        .red_err(b_red_err), .last_gnt(b_last_gnt), .fwd_cnt0(b_cnt0), .fwd_cnt1(b_cnt1)
    );

    assign b_i0.req = i0.req;
    assign b_i0.src = i0.src;
    assign b_i0.dst = i0.dst;
    assign b_i0.dat = i0.dat;
    assign b_i0.red = i0.red;
    assign b_i1.req = i1.req;
    assign b_i1.src = i1.src;
    assign b_i1.dst = i1.dst;
    assign b_i1.dat = i1.dat;
    assign b_i1.red = i1.red;
    assign b_o0.ack = o0.ack;

    // Reference model state: pending requests, their messages, counts, last winner, sticky error.
    int   checks = 0;
    int   errors = 0;
    bit   pend [2];
    msg_t m [2];
    int   m_cnt [2];
    bit   m_last;
    bit   m_red;
    bit   got_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_red(input msg_t x);
        logic [31:0] v;
        logic [3:0]  r;
        v = {x.src, x.dst, x.dat};
        r = 4'h0;
        while (v != 0) begin
            r = r ^ v[3:0];
            v = v >> 4;
        end
        return r;
    endfunction

    function automatic msg_t rand_msg(input bit good);
        msg_t r;
        r.src = 8'($urandom);
        r.dst = 8'($urandom);
        r.dat = 16'($urandom);
        r.red = 4'h0;
        r.red = good ? ref_red(r) : (ref_red(r) ^ 4'h1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs();
        i0.req = pend[0];
        {i0.src, i0.dst, i0.dat, i0.red} = m[0];
        i1.req = pend[1];
        {i1.src, i1.dst, i1.dat, i1.red} = m[1];
    endtask

    task automatic check_model();
        chk("fwd_cnt0", cnt0, 64'(m_cnt[0] % 256));
        chk("fwd_cnt1", cnt1, 64'(m_cnt[1] % 256));
        chk("last_gnt", last_gnt, m_last);
        chk("red_err", red_err, m_red);
        chk("b_fwd_cnt0", b_cnt0, 64'(m_cnt[0] % 4));
        chk("b_fwd_cnt1", b_cnt1, 64'(m_cnt[1] % 4));
        chk("b_last_gnt", b_last_gnt, m_last);
        chk("b_red_err", b_red_err, 0);
    endtask

    // One full transaction; called with the arbiter in IDLE.
    task automatic do_txn(input int stall, input bit renew0, input bit abort);
        int   cyc;
        bit   w;
        msg_t exp_m;
        w = (pend[0] && pend[1]) ? !m_last : pend[1];
        exp_m = m[w];
        drive_inputs();
        cyc = 0;
        while (!(i0.ack || i1.ack) && cyc < 20) begin tick(); cyc++; end
        chk("grant_latency", cyc, 1);
        got_w = i1.ack;
        chk("grant_ack", {i1.ack, i0.ack}, w ? 2'b10 : 2'b01);
        chk("b_grant_ack", {b_i1.ack, b_i0.ack}, w ? 2'b10 : 2'b01);
        chk("oreq_low_in_grant", o0.req, 0);
        pend[w] = 1'b0;
        drive_inputs();
        cyc = 0;
        while (!o0.req && cyc < 20) begin tick(); cyc++; end
        chk("release_latency", cyc, 1);
        chk("o0_msg", {o0.src, o0.dst, o0.dat, o0.red}, exp_m);
        chk("acks_low_in_send", {i1.ack, i0.ack}, 0);
        if (abort) return;
        for (int i = 0; i < stall; i++) begin
            if (renew0 && i == 2) begin
                m[0] = rand_msg(1'b1);
                pend[0] = 1'b1;
                drive_inputs();
            end
            tick();
            chk("o0_stable", {o0.src, o0.dst, o0.dat, o0.red}, exp_m);
            chk("o0_req_held", o0.req, 1);
            chk("no_ack_in_stall", {i1.ack, i0.ack}, 0);
        end
        o0.ack = 1'b1;
        cyc = 0;
        while (o0.req && cyc < 20) begin tick(); cyc++; end
        chk("o0_req_drop", cyc, 1);
        chk("no_ack_in_drain", {i1.ack, i0.ack}, 0);
        o0.ack = 1'b0;
        tick();
        m_cnt[w]++;
        m_last = w;
        if (ref_red(exp_m) != exp_m.red) m_red = 1'b1;
        check_model();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        o0.ack = 1'b0;
        drive_inputs();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_last = 1'b1;
        m_red = 1'b0;
        repeat (2) tick();
        chk("rst_oreq", o0.req, 0);
        chk("rst_acks", {i1.ack, i0.ack}, 0);
        chk("rst_o0_msg", {o0.src, o0.dst, o0.dat, o0.red}, 0);
        check_model();
        reset_n = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("one_ack", i0.ack & i1.ack, 0);
            chk("ack_vs_oreq", (i0.ack | i1.ack) & o0.req, 0);
        end
    end

    initial begin
        m[0] = '0;
        m[1] = '0;
        do_reset();

        // Single i0 message with known fields.
        m[0] = '{src: 8'd9, dst: 8'd10, dat: 16'd3, red: 4'h0};
        m[0].red = ref_red(m[0]);
        pend[0] = 1'b1;
        do_txn(0, 1'b0, 1'b0);
        chk("t1_o0_dst", o0.dst, 10);
        chk("t1_o0_dat", o0.dat, 3);

        // Saturation: both inputs always requesting, alternation from reset.
        do_reset();
        m[0] = rand_msg(1'b1);
        m[1] = rand_msg(1'b1);
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_txn(0, 1'b0, 1'b0);
            chk("alt_order", got_w, 64'(i % 2));
            if (i < 5) begin
                m[got_w] = rand_msg(1'b1);
                m[got_w].dat = 16'(i + 100);
                m[got_w].red = ref_red(m[got_w]);
                pend[got_w] = 1'b1;
            end
        end
        chk("sat_cnt0", cnt0, 3);
        chk("sat_cnt1", cnt1, 3);
        if (pend[0] || pend[1]) do_txn(0, 1'b0, 1'b0);

        // Corrupted redundancy on i1, then good traffic: flag is sticky.
        m[1] = rand_msg(1'b0);
        pend[1] = 1'b1;
        do_txn(0, 1'b0, 1'b0);
        chk("red_err_set", red_err, 1);
        for (int i = 0; i < 3; i++) begin
            m[i % 2] = rand_msg(1'b1);
            pend[i % 2] = 1'b1;
            do_txn(1, 1'b0, 1'b0);
        end
        chk("red_err_sticky", red_err, 1);
        chk("b_red_err_off", b_red_err, 0);

        // Sink stall with a new i0 request arriving mid-stall.
        m[0] = rand_msg(1'b1);
        pend[0] = 1'b1;
        do_txn(20, 1'b1, 1'b0);
        do_txn(0, 1'b0, 1'b0);

        // o0_ack while idle is ignored.
        o0.ack = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_ack_ignored", {o0.req, i1.ack, i0.ack}, 0);
        end
        o0.ack = 1'b0;
        tick();
        check_model();

        // Reset while in SEND, with i1 waiting.
        m[0] = rand_msg(1'b1);
        pend[0] = 1'b1;
        do_txn(0, 1'b0, 1'b1);
        m[1] = rand_msg(1'b1);
        pend[1] = 1'b1;
        drive_inputs();
        tick();
        chk("loser_ignored", {i1.ack, i0.ack}, 0);
        #2 reset_n = 1'b0;
        #1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_last = 1'b1;
        m_red = 1'b0;
        chk("async_oreq", o0.req, 0);
        chk("async_acks", {i1.ack, i0.ack}, 0);
        chk("async_o0_msg", {o0.src, o0.dst, o0.dat, o0.red}, 0);
        check_model();
        @(negedge clk);
        reset_n = 1'b1;
        do_txn(0, 1'b0, 1'b0);
        chk("post_rst_winner", got_w, 1);

        // Mirror instance has 2-bit counters: watch the wrap.
        for (int i = 0; i < 5; i++) begin
            m[0] = rand_msg(1'b1);
            pend[0] = 1'b1;
            do_txn(0, 1'b0, 1'b0);
            chk("b_cnt_wrap", b_cnt0, 64'((i + 1) % 4));
        end

        // Randomised traffic.
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    m[k] = rand_msg($urandom_range(0, 7) != 0);
                    pend[k] = 1'b1;
                end
            end
            if (!pend[0] && !pend[1]) begin
                m[1] = rand_msg(1'b1);
                pend[1] = 1'b1;
            end
            do_txn(int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
